i2c_master_engine: RTL and testbench
====================================

# i2c_master_engine

Byte-level I2C master that sits directly downstream of the APB-side TX FIFO and upstream of the RX FIFO. It pops bytes from the TX FIFO read port and serialises them onto open-drain SCL/SDA. It deserialises slave data into the RX FIFO write port. Transaction parameters (address, direction, length) come from the bridge register block; status goes back to it.

## Interface
- CLK_DIV, 4: PCLK cycles per SCL quarter-period; SCL period = 4*CLK_DIV cycles; legal ≥ 2.
- PCLK  in  1  core clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- enable  in  1  start request, sampled only in IDLE.
- slave_addr  in  7  target address, latched on accepted enable.
- rw  in  1  0 = write, 1 = read; latched on accepted enable.
- byte_count  in  8  data bytes to transfer; latched; 0 = address-only probe.
- tx_data  in  8  TX FIFO read_data (show-ahead).
- tx_empty  in  1  TX FIFO read_empty.
- tx_rd_inc  out  1  one-cycle pop pulse to TX FIFO read_increment.
- rx_data  out  8  byte to RX FIFO write_data.
- rx_full  in  1  RX FIFO write_full.
- rx_wr_inc  out  1  one-cycle push pulse to RX FIFO write_increment.
- sda_in  in  1  synchronised SDA line level.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- busy  out  1  high from accepted enable until STOP completes.
- done  out  1  one-cycle pulse when STOP completes.
- ack_error  out  1  set on any NACK from slave; cleared on next accepted enable.

## Operation
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0, tx_rd_inc=0, rx_wr_inc=0, rx_data=0x00, state IDLE, counters 0.
- Quarter tick: divider counts 0..CLK_DIV-1 and ticks on wrap. Divider is held at 0 in IDLE and in stall states.
- Bit frame = 4 quarters:
  - Q0: SCL low; SDA driven to the new value at Q0 start.
  - Q1 and Q2: SCL released.
  - sda_in sampled at the Q1→Q2 boundary.
  - Q3: SCL low.
- States:
  - IDLE: enable=1 → START. Latches inputs, busy=1, ack_error=0.
  - START: SDA pulled low with SCL released for 1 quarter, then SCL low for 1 quarter → ADDR.
  - ADDR: shifts {slave_addr, rw}, MSB first → ADDR_ACK.
  - ADDR_ACK: SDA released.
    - Sampled 1 → ack_error=1, STOP.
    - Else byte_count==0 → STOP; rw=0 → WAIT_TX; rw=1 → READ.
  - WAIT_TX: SCL held low. When tx_empty=0: latch tx_data, pulse tx_rd_inc that same cycle → WRITE.
  - WRITE: shifts the 8 latched bits, MSB first → WRITE_ACK.
  - WRITE_ACK: SDA released; decrement remaining count.
    - NACK → ack_error=1, STOP.
    - Else remaining==0 → STOP; else → WAIT_TX.
  - READ: SDA released; shifts 8 sampled bits, MSB first → WAIT_RX.
  - WAIT_RX: SCL held low. When rx_full=0: present byte on rx_data, pulse rx_wr_inc → READ_ACK.
  - READ_ACK: sda_oe=1 (ACK) if bytes remain after this one; sda_oe=0 (NACK) on the last byte. Then → READ or STOP.
  - STOP: SDA low with SCL low, then SCL released, then SDA released, 1 quarter each. Pulse done; busy=0 → IDLE.
- Boundary conditions:
  - enable while busy is ignored.
  - A stall in WAIT_TX or WAIT_RX may last indefinitely; SCL stays low and SDA holds.
  - rx_data holds its value until the next push.
  - byte_count=255 is legal and needs no wrap.
  - PRESET mid-transfer forces all outputs to reset values immediately. No STOP is generated.
  - No clock stretching and no arbitration.

## Timing
- busy rises 1 cycle after enable is sampled in IDLE. sda_oe rises on that same edge (start condition).
- START = 2 quarters; each of the 9 address/ack bits = 4 quarters; STOP = 3 quarters.
- Write of N bytes with no stalls: (2 + 36 + 36N + 3) × CLK_DIV cycles from START to the done pulse.
- tx_rd_inc and rx_wr_inc are exactly 1 cycle wide and never both high.

## Test plan
- Write 0x50 with 2 bytes; FIFO holds 0xA5, 0x3C; slave ACKs all (CLK_DIV=4):
  - SDA bytes are 0xA0, 0xA5, 0x3C.
  - Two tx_rd_inc pulses; done at cycle (2+36+72+3)×4 = 452; ack_error=0.
- Address NACK (sda_in=1 in ACK slot), write of 3 bytes:
  - ack_error=1 and STOP follows.
  - Zero tx_rd_inc pulses; busy falls with done.
- Read 0x51, byte_count=2; slave drives 0x5A then 0xC3:
  - rx_wr_inc pulses with rx_data=0x5A, then 0xC3.
  - sda_oe=1 in the first ACK slot, 0 in the second; then STOP.
- tx_empty=1 for 100 cycles before the second write byte:
  - scl_oe stays 1 and sda_oe stays constant throughout.
  - Transfer resumes; byte correct; done delayed by ~100 cycles.
- rx_full=1 for 50 cycles after the first read byte:
  - No rx_wr_inc and SCL held low during the stall.
  - Exactly one push once rx_full=0.
- PRESET asserted mid data byte:
  - All outputs return to reset values asynchronously.
  - A subsequent enable runs a clean transaction.
  - enable pulsed while busy has no effect.

Source files
------------

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master: pops TX FIFO bytes onto open-drain SCL/SDA and pushes
// received bytes into the RX FIFO. One bit frame is four divider quarters.
module i2c_master_engine #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       enable,
  input  logic [6:0] slave_addr,
  input  logic       rw,
  input  logic [7:0] byte_count,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rd_inc,
  output logic [7:0] rx_data,
  input  logic       rx_full,
  output logic       rx_wr_inc,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WAIT_TX, WRITE, WRITE_ACK,
    READ, WAIT_RX, READ_ACK, STOP
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [1:0]       qtr, qtr_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, remain, remain_n, rx_data_n;
  logic             rw_q, rw_n;
  logic             scl_oe_n, sda_oe_n, busy_n, done_n, ack_error_n;
  logic             tx_rd_inc_n, rx_wr_inc_n, frame_low;
  logic             tick;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  // State and output registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      div       <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      remain    <= '0;
      rw_q      <= 1'b0;
      rx_data   <= '0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      tx_rd_inc <= 1'b0;
      rx_wr_inc <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      qtr       <= qtr_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      remain    <= remain_n;
      rw_q      <= rw_n;
      rx_data   <= rx_data_n;
      scl_oe    <= scl_oe_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      done      <= done_n;
      ack_error <= ack_error_n;
      tx_rd_inc <= tx_rd_inc_n;
      rx_wr_inc <= rx_wr_inc_n;
    end
  end

  // Next-state logic; line levels are decoded from the next state so they are registered
  always_comb begin
    state_n     = state;
    qtr_n       = tick ? qtr + 2'd1 : qtr;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    remain_n    = remain;
    rw_n        = rw_q;
    rx_data_n   = rx_data;
    busy_n      = busy;
    done_n      = 1'b0;
    ack_error_n = ack_error;
    tx_rd_inc_n = 1'b0;
    rx_wr_inc_n = 1'b0;
    scl_oe_n    = 1'b0;
    sda_oe_n    = 1'b0;
    frame_low   = 1'b0;

    if (state == IDLE || state == WAIT_TX || state == WAIT_RX) div_n = '0;
    else div_n = tick ? '0 : div + DIV_W'(1);

    case (state)
      IDLE: begin
        qtr_n = '0;
        if (enable) begin
          state_n     = START;
          bit_cnt_n   = '0;
          shreg_n     = {slave_addr, rw};
          rw_n        = rw;
          remain_n    = byte_count;
          busy_n      = 1'b1;
          ack_error_n = 1'b0;
        end
      end
      START: if (tick && qtr == 2'd1) begin
        state_n = ADDR;
        qtr_n   = '0;
      end
      ADDR, WRITE: if (tick && qtr == 2'd3) begin
        shreg_n = {shreg[6:0], 1'b0};
        if (bit_cnt == 3'd7) begin
          bit_cnt_n = '0;
          state_n   = (state == ADDR) ? ADDR_ACK : WRITE_ACK;
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      ADDR_ACK, WRITE_ACK: begin
        if (tick && qtr == 2'd1 && sda_in) ack_error_n = 1'b1;
        if (tick && qtr == 2'd3) begin
          if (ack_error || remain == 8'd0) state_n = STOP;
          else if (state == ADDR_ACK && rw_q) state_n = READ;
          else if (!tx_empty) begin
            state_n     = WRITE;
            shreg_n     = tx_data;
            tx_rd_inc_n = 1'b1;
            remain_n    = remain - 8'd1;
          end else state_n = WAIT_TX;
        end
      end
      WAIT_TX: if (!tx_empty) begin
        state_n     = WRITE;
        shreg_n     = tx_data;
        tx_rd_inc_n = 1'b1;
        remain_n    = remain - 8'd1;
      end
      READ: begin
        if (tick && qtr == 2'd1) shreg_n = {shreg[6:0], sda_in};
        if (tick && qtr == 2'd3) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            if (!rx_full) begin
              state_n     = READ_ACK;
              rx_data_n   = shreg;
              rx_wr_inc_n = 1'b1;
              remain_n    = remain - 8'd1;
            end else state_n = WAIT_RX;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      WAIT_RX: if (!rx_full) begin
        state_n     = READ_ACK;
        rx_data_n   = shreg;
        rx_wr_inc_n = 1'b1;
        remain_n    = remain - 8'd1;
      end
      READ_ACK: if (tick && qtr == 2'd3) state_n = (remain == 8'd0) ? STOP : READ;
      STOP: if (tick && qtr == 2'd2) begin
        state_n = IDLE;
        qtr_n   = '0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // SCL is low in the first and last quarter of every bit frame
    frame_low = (qtr_n == 2'd0) || (qtr_n == 2'd3);
    case (state_n)
      START: begin
        scl_oe_n = (qtr_n == 2'd1);
        sda_oe_n = 1'b1;
      end
      ADDR, WRITE: begin
        scl_oe_n = frame_low;
        sda_oe_n = ~shreg_n[7];
      end
      ADDR_ACK, WRITE_ACK, READ: scl_oe_n = frame_low;
      READ_ACK: begin
        scl_oe_n = frame_low;
        sda_oe_n = (remain_n != 8'd0);
      end
      WAIT_TX, WAIT_RX: begin
        scl_oe_n = 1'b1;
        sda_oe_n = sda_oe;
      end
      STOP: begin
        scl_oe_n = (qtr_n == 2'd0);
        sda_oe_n = (qtr_n != 2'd2);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_master_engine.sv
// Scoreboard bench for i2c_master_engine: a bit-level slave model checks SDA bytes,
// master ACKs, FIFO handshakes, latency, stalls and asynchronous reset.
module tb_i2c_master_engine;
  localparam int unsigned CLK_DIV = 4;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       enable;
  logic [6:0] slave_addr;
  logic       rw;
  logic [7:0] byte_count;
  logic [7:0] tx_data = 8'h00;
  logic       tx_empty = 1'b1;
  logic       tx_rd_inc;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_wr_inc;
  logic       sda_in;
  logic       scl_oe, sda_oe, busy, done, ack_error;

  i2c_master_engine #(.CLK_DIV(CLK_DIV)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .slave_addr(slave_addr), .rw(rw),
    .byte_count(byte_count), .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd_inc(tx_rd_inc),
    .rx_data(rx_data), .rx_full(rx_full), .rx_wr_inc(rx_wr_inc), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done), .ack_error(ack_error)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues and models
  logic [7:0] tx_fifo[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] rd_q[$];
  logic       mack_q[$];
  logic       tx_stall = 1'b0;
  logic       addr_ack = 1'b1;
  int         tx_pulses = 0, rx_pulses = 0, stops = 0, pulse_err = 0;
  logic       prev_tx = 1'b0, prev_rx = 1'b0;

  logic       pull = 1'b0;
  assign sda_in = ~sda_oe & ~pull;

  // TX FIFO model and handshake pulse monitor
  always @(negedge PCLK) begin
    if (PRESET) begin
      prev_tx = 1'b0;
      prev_rx = 1'b0;
    end else begin
      if (tx_rd_inc) begin
        if (prev_tx) pulse_err++; else tx_pulses++;
        if (tx_fifo.size() > 0) tx_fifo.delete(0);
      end
      if (rx_wr_inc) begin
        if (prev_rx) pulse_err++; else rx_pulses++;
        if (rx_exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        else check("rx_extra", 32'(rx_data), 32'hFFFF_FFFF);
      end
      if (tx_rd_inc && rx_wr_inc) pulse_err++;
      prev_tx = tx_rd_inc;
      prev_rx = rx_wr_inc;
    end
    tx_empty = tx_stall || (tx_fifo.size() == 0);
    tx_data  = (tx_fifo.size() > 0) ? tx_fifo[0] : 8'h00;
  end

  // Bit-level slave: decodes START/STOP/bytes, ACKs, and drives read data
  logic       in_frame = 1'b0, is_read = 1'b0, prev_scl = 1'b0, prev_line = 1'b1;
  logic       line_now, have = 1'b0;
  logic [7:0] shift = 8'h00, cur = 8'h00;
  int         bit_idx = 0, grp = 0;

  always @(negedge PCLK) begin
    if (PRESET) begin
      in_frame = 1'b0; pull = 1'b0; bit_idx = 0; grp = 0; is_read = 1'b0;
      prev_scl = 1'b0; prev_line = 1'b1;
    end else begin
      line_now = sda_in;
      if (!scl_oe && !prev_scl && prev_line && !line_now) begin
        in_frame = 1'b1; bit_idx = 0; grp = 0; is_read = 1'b0;
      end else if (!scl_oe && !prev_scl && !prev_line && line_now && in_frame) begin
        in_frame = 1'b0;
        stops++;
      end else if (in_frame && prev_scl && !scl_oe) begin
        if (bit_idx < 8) begin
          shift = {shift[6:0], line_now};
          if (bit_idx == 7) begin
            if (grp == 0) is_read = line_now;
            if (exp_q.size() > 0) check("sda_byte", 32'(shift), 32'(exp_q.pop_front()));
            else check("sda_extra", 32'(shift), 32'hFFFF_FFFF);
          end
        end else if (grp > 0 && is_read) begin
          if (mack_q.size() > 0) check("master_ack", 32'(!line_now), 32'(mack_q.pop_front()));
          else check("mack_extra", 32'(!line_now), 32'hFFFF_FFFF);
        end
        bit_idx++;
      end else if (in_frame && !prev_scl && scl_oe) begin
        if (bit_idx == 9) begin
          bit_idx = 0;
          grp++;
        end
        if (bit_idx == 8) pull = (grp == 0) ? addr_ack : !is_read;
        else if (is_read && grp > 0) begin
          if (bit_idx == 0) begin
            have = (rd_q.size() > 0);
            if (have) cur = rd_q.pop_front();
          end
          pull = have && !cur[3'(7 - bit_idx)];
        end else pull = 1'b0;
      end
      prev_scl  = scl_oe;
      prev_line = line_now;
    end
  end

  int lat;

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] n, output int l);
    @(negedge PCLK);
    slave_addr = a; rw = r; byte_count = n; enable = 1'b1;
    @(negedge PCLK);
    enable = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("start_lines", 32'({scl_oe, sda_oe}), 32'b01);
    check("ack_err_clear", 32'(ack_error), 32'd0);
    l = 0;
    while (!done && l < 5000) begin
      @(negedge PCLK);
      l++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge PCLK);
    check("done_width", 32'(done), 32'd0);
  endtask

  task automatic clear_counts();
    tx_pulses = 0; rx_pulses = 0; stops = 0;
  endtask

  logic scl_bad, sda_bad, inc_bad, sda0;
  int   k;

  initial begin
    PRESET = 1'b1; enable = 1'b0; slave_addr = '0; rw = 1'b0; byte_count = '0; rx_full = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_outs", 32'({scl_oe, sda_oe, busy, done, ack_error, tx_rd_inc, rx_wr_inc, rx_data}), 32'd0);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    check("idle_outs", 32'({scl_oe, sda_oe, busy, done, ack_error, tx_rd_inc, rx_wr_inc, rx_data}), 32'd0);

    // Write 0x50, two bytes, all ACKed
    clear_counts();
    tx_fifo.push_back(8'hA5); tx_fifo.push_back(8'h3C);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    repeat (2) @(negedge PCLK);
    run_txn(7'h50, 1'b0, 8'd2, lat);
    check("wr_latency", 32'(lat), 32'd452);
    check("wr_ack_err", 32'(ack_error), 32'd0);
    check("wr_pops", 32'(tx_pulses), 32'd2);
    check("wr_stop", 32'(stops), 32'd1);
    check("wr_bytes_left", 32'(exp_q.size()), 32'd0);

    // Address NACK on a 3-byte write
    clear_counts();
    addr_ack = 1'b0;
    tx_fifo.push_back(8'h11); tx_fifo.push_back(8'h22); tx_fifo.push_back(8'h33);
    exp_q.push_back(8'hA0);
    repeat (2) @(negedge PCLK);
    run_txn(7'h50, 1'b0, 8'd3, lat);
    check("nack_latency", 32'(lat), 32'd164);
    check("nack_ack_err", 32'(ack_error), 32'd1);
    check("nack_pops", 32'(tx_pulses), 32'd0);
    check("nack_stop", 32'(stops), 32'd1);
    tx_fifo.delete();
    addr_ack = 1'b1;

    // Read 0x51, two bytes
    clear_counts();
    rd_q.push_back(8'h5A); rd_q.push_back(8'hC3);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    rx_exp_q.push_back(8'h5A); rx_exp_q.push_back(8'hC3);
    mack_q.push_back(1'b1); mack_q.push_back(1'b0);
    repeat (2) @(negedge PCLK);
    run_txn(7'h51, 1'b1, 8'd2, lat);
    check("rd_latency", 32'(lat), 32'd452);
    check("rd_pushes", 32'(rx_pulses), 32'd2);
    check("rd_ack_err", 32'(ack_error), 32'd0);
    check("rd_stop", 32'(stops), 32'd1);
    check("rd_left", 32'(exp_q.size() + rx_exp_q.size() + mack_q.size()), 32'd0);

    // TX FIFO empty for ~100 cycles before the second byte
    clear_counts();
    tx_fifo.push_back(8'hA5); tx_fifo.push_back(8'h3C);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    scl_bad = 1'b0; sda_bad = 1'b0;
    repeat (2) @(negedge PCLK);
    fork
      run_txn(7'h50, 1'b0, 8'd2, lat);
      begin
        k = 0;
        while (!tx_rd_inc && k < 2000) begin @(negedge PCLK); k++; end
        check("stall_first_pop", 32'(tx_rd_inc), 32'd1);
        tx_stall = 1'b1;
        repeat (150) @(negedge PCLK);
        sda0 = sda_oe;
        for (int i = 0; i < 100; i++) begin
          @(negedge PCLK);
          if (!scl_oe) scl_bad = 1'b1;
          if (sda_oe !== sda0) sda_bad = 1'b1;
        end
        tx_stall = 1'b0;
      end
    join
    check("txstall_scl_low", 32'(scl_bad), 32'd0);
    check("txstall_sda_hold", 32'(sda_bad), 32'd0);
    check("txstall_latency", 32'(lat >= 555 && lat <= 565), 32'd1);
    check("txstall_pops", 32'(tx_pulses), 32'd2);
    check("txstall_left", 32'(exp_q.size()), 32'd0);
    check("rx_hold", 32'(rx_data), 32'hC3);

    // RX FIFO full for 50 cycles in front of the second byte's push
    clear_counts();
    rd_q.push_back(8'h5A); rd_q.push_back(8'hC3);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    rx_exp_q.push_back(8'h5A); rx_exp_q.push_back(8'hC3);
    mack_q.push_back(1'b1); mack_q.push_back(1'b0);
    scl_bad = 1'b0; inc_bad = 1'b0;
    repeat (2) @(negedge PCLK);
    fork
      run_txn(7'h51, 1'b1, 8'd2, lat);
      begin
        k = 0;
        while (!rx_wr_inc && k < 2000) begin @(negedge PCLK); k++; end
        check("rxstall_first_push", 32'(rx_wr_inc), 32'd1);
        rx_full = 1'b1;
        repeat (150) @(negedge PCLK);
        for (int i = 0; i < 50; i++) begin
          @(negedge PCLK);
          if (!scl_oe) scl_bad = 1'b1;
          if (rx_wr_inc) inc_bad = 1'b1;
        end
        rx_full = 1'b0;
      end
    join
    check("rxstall_scl_low", 32'(scl_bad), 32'd0);
    check("rxstall_no_push", 32'(inc_bad), 32'd0);
    check("rxstall_pushes", 32'(rx_pulses), 32'd2);
    check("rxstall_latency", 32'(lat >= 505 && lat <= 515), 32'd1);
    check("rxstall_left", 32'(exp_q.size() + rx_exp_q.size() + mack_q.size()), 32'd0);

    // Asynchronous reset in the middle of a data byte
    tx_fifo.push_back(8'hA5); tx_fifo.push_back(8'h3C);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    @(negedge PCLK);
    slave_addr = 7'h50; rw = 1'b0; byte_count = 8'd2; enable = 1'b1;
    @(negedge PCLK);
    enable = 1'b0;
    k = 0;
    while (!tx_rd_inc && k < 2000) begin @(negedge PCLK); k++; end
    check("abort_pop_seen", 32'(tx_rd_inc), 32'd1);
    repeat (40) @(negedge PCLK);
    check("abort_busy", 32'(busy), 32'd1);
    #2 PRESET = 1'b1;
    #1 check("async_reset", 32'({scl_oe, sda_oe, busy, done, ack_error, tx_rd_inc, rx_wr_inc, rx_data}), 32'd0);
    tx_fifo.delete(); exp_q.delete();
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);

    // Clean one-byte write after reset; an enable pulse while busy must be ignored
    clear_counts();
    tx_fifo.push_back(8'h96);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h96);
    repeat (2) @(negedge PCLK);
    fork
      run_txn(7'h2D, 1'b0, 8'd1, lat);
      begin
        repeat (200) @(negedge PCLK);
        slave_addr = 7'h7F; rw = 1'b1; byte_count = 8'd5; enable = 1'b1;
        @(negedge PCLK);
        enable = 1'b0;
      end
    join
    check("post_rst_latency", 32'(lat), 32'd308);
    check("post_rst_pops", 32'(tx_pulses), 32'd1);
    check("post_rst_left", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge PCLK);
    check("busy_enable_ignored", 32'(busy), 32'd0);
    check("pulse_shape", 32'(pulse_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
